// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding and width helpers for the UART TX arbiter
package uart_arb_pkg;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    localparam int REQ_IDX_W_DEFAULT = $clog2(4);
    function automatic int req_idx_w(input int num_req);
        return $clog2(num_req);
    endfunction
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout);
    endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: round-robin pick of the first set request above last_winner, with wrap
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] j;
    // scan from farthest to nearest so the nearest requester above last_winner wins
    always_comb begin
        pick = '0;
        idx  = '0;
        j    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(last_winner) + k) % NUM_REQ);
            if (req[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the UART TX write port
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         tx_full,
    output logic                         wr_uart,
    output logic [DATA_BITS-1:0]         w_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         abort
);
    localparam int REQ_IDX_W = req_idx_w(NUM_REQ);
    localparam int CNT_W     = cnt_w(TIMEOUT);

    logic [0:0]           state;
    logic [REQ_IDX_W-1:0] g_idx, last_winner, pick_idx;
    logic [NUM_REQ-1:0]   pick;
    logic [CNT_W-1:0]     cnt;
    logic                 xfer, g_valid, g_last, done;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_IDX_W)) u_picker (
        .req         (req_valid),
        .last_winner (last_winner),
        .pick        (pick),
        .idx         (pick_idx)
    );

    assign xfer      = state == XFER;
    assign g_valid   = req_valid[g_idx];
    assign g_last    = req_last[g_idx];
    assign req_ready = tx_full ? '0 : grant;
    assign wr_uart   = xfer & g_valid & ~tx_full;
    assign w_data    = xfer ? req_data[g_idx*DATA_BITS +: DATA_BITS] : '0;
    assign done      = wr_uart & g_last;
    assign abort     = xfer & ~g_valid & (cnt == CNT_W'(TIMEOUT - 1));
    assign busy      = xfer;

    // FSM, grant ownership and idle-timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            g_idx       <= '0;
            last_winner <= REQ_IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
        end else if (!xfer) begin
            cnt <= '0;
            if (|req_valid) begin
                state <= XFER;
                grant <= pick;
                g_idx <= pick_idx;
            end
        end else if (done || abort) begin
            state       <= IDLE;
            grant       <= '0;
            last_winner <= g_idx;
            cnt         <= '0;
        end else begin
            cnt <= wr_uart ? '0 : (!g_valid ? cnt + CNT_W'(1) : cnt);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  v = '0;
    logic [N-1:0]  l = '0;
    logic [N*DB-1:0] d = '0;
    logic          tx_full = 1'b0;
    logic [N-1:0]  rdy, grant;
    logic          wr_uart, busy, abort;
    logic [DB-1:0] w_data;
    int            total = 0;
    int            bad = 0;
    int            aborts = 0;
    logic [7:0]    fifo[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v),
        .req_data  (d),
        .req_last  (l),
        .req_ready (rdy),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .grant     (grant),
        .busy      (busy),
        .abort     (abort)
    );

    // capture what the TX FIFO would receive and count abort pulses
    always @(posedge clk) begin
        if (!rst && wr_uart) fifo.push_back(w_data);
        if (!rst && abort) aborts++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input logic vv, input logic [7:0] dd, input logic ll);
        v[i] = vv;
        d[i*DB +: DB] = dd;
        l[i] = ll;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v = '0;
        l = '0;
        d = '0;
        tx_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base, i1, k;
        logic done0, a0, a1;
        logic [3:0] exp_g [10];
        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_wdata", w_data, 0);

        // single packet from requester 2
        do_reset();
        base = fifo.size();
        drv(2, 1, 8'h11, 0);
        #1 chk("sp_idle_grant", grant, 0);
        chk("sp_idle_rdy", rdy, 0);
        tick();
        #1 chk("sp_g1", grant, 4'b0100);
        chk("sp_wr1", wr_uart, 1);
        chk("sp_d1", w_data, 8'h11);
        chk("sp_rdy1", rdy, 4'b0100);
        tick();
        drv(2, 1, 8'h22, 0);
        #1 chk("sp_g2", grant, 4'b0100);
        chk("sp_d2", w_data, 8'h22);
        tick();
        drv(2, 1, 8'h33, 1);
        #1 chk("sp_g3", grant, 4'b0100);
        chk("sp_d3", w_data, 8'h33);
        tick();
        drv(2, 0, 8'h00, 0);
        #1 chk("sp_g_end", grant, 0);
        chk("sp_busy_end", busy, 0);
        chk("sp_n", fifo.size() - base, 3);
        chk("sp_b0", fifo[base], 8'h11);
        chk("sp_b1", fifo[base+1], 8'h22);
        chk("sp_b2", fifo[base+2], 8'h33);

        // round robin with every requester holding a 1-byte packet
        do_reset();
        base = fifo.size();
        exp_g = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd0, 4'd8, 4'd0, 4'd1};
        for (int i = 0; i < N; i++) drv(i, 1, 8'hA0 + 8'(i), 1);
        for (int c = 0; c < 10; c++) begin
            #1 chk($sformatf("rr_g%0d", c), grant, exp_g[c]);
            tick();
        end
        v = '0;
        l = '0;
        chk("rr_n", fifo.size() - base, 5);
        chk("rr_b0", fifo[base], 8'hA0);
        chk("rr_b1", fifo[base+1], 8'hA1);
        chk("rr_b2", fifo[base+2], 8'hA2);
        chk("rr_b3", fifo[base+3], 8'hA3);
        chk("rr_b4", fifo[base+4], 8'hA0);

        // requester 1 packet under toggling backpressure while requester 0 waits
        do_reset();
        base = fifo.size();
        aborts = 0;
        drv(1, 1, 8'hB0, 0);
        tick();
        i1 = 0;
        done0 = 1'b0;
        k = 0;
        while (!(i1 == 5 && done0) && k < 40) begin
            tx_full = ~tx_full;
            drv(0, !done0, 8'hC0, 1);
            drv(1, i1 < 5, 8'hB0 + 8'(i1), i1 == 4);
            #1;
            a0 = v[0] & rdy[0];
            a1 = v[1] & rdy[1];
            if (i1 < 5) chk($sformatf("bp_g%0d", k), grant, 4'b0010);
            tick();
            if (a1) i1++;
            if (a0) done0 = 1'b1;
            k++;
        end
        chk("bp_bounded", k < 40, 1);
        v = '0;
        l = '0;
        tx_full = 1'b0;
        chk("bp_n", fifo.size() - base, 6);
        for (int i = 0; i < 5; i++) chk($sformatf("bp_b%0d", i), fifo[base+i], 8'hB0 + 8'(i));
        chk("bp_b5", fifo[base+5], 8'hC0);
        chk("bp_no_abort", aborts, 0);

        // timeout after a single byte without last
        do_reset();
        aborts = 0;
        drv(3, 1, 8'h5A, 0);
        #1 chk("to_g0", grant, 0);
        tick();
        #1 chk("to_g1", grant, 4'b1000);
        chk("to_wr1", wr_uart, 1);
        chk("to_d1", w_data, 8'h5A);
        tick();
        drv(3, 0, 8'h00, 0);
        drv(0, 1, 8'h77, 1);
        for (int c = 2; c <= 9; c++) begin
            #1 chk($sformatf("to_abort%0d", c), abort, c == 9);
            if (c == 9) begin
                chk("to_wr9", wr_uart, 0);
                chk("to_g9", grant, 4'b1000);
            end
            tick();
        end
        #1 chk("to_g10", grant, 0);
        chk("to_abort10", abort, 0);
        tick();
        #1 chk("to_g11", grant, 4'b0001);
        chk("to_wr11", wr_uart, 1);
        chk("to_d11", w_data, 8'h77);
        tick();
        v = '0;
        l = '0;
        chk("to_aborts", aborts, 1);

        // reset in the middle of a 4-byte packet
        do_reset();
        drv(2, 1, 8'hD0, 0);
        tick();
        #1 chk("mr_wr1", wr_uart, 1);
        chk("mr_d1", w_data, 8'hD0);
        tick();
        drv(2, 1, 8'hD1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(2, 0, 8'h00, 0);
        drv(0, 1, 8'hE0, 1);
        drv(3, 1, 8'hE3, 1);
        #1 chk("mr_grant", grant, 0);
        chk("mr_busy", busy, 0);
        chk("mr_wr", wr_uart, 0);
        chk("mr_rdy", rdy, 0);
        chk("mr_wdata", w_data, 0);
        chk("mr_abort", abort, 0);
        tick();
        #1 chk("mr_win0", grant, 4'b0001);
        chk("mr_d0", w_data, 8'hE0);
        tick();
        v = '0;
        l = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
